// File: rtl/pulsegap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pulsegap_sequencer
// Purpose  : Loads a pulse/gap pattern into an external 16-bit circular shift
//            register, runs it for a programmed number of periods and gates
//            its serial output. Optional pattern self-check: PULSEGAP_CHECK_EN.
// Revision : 1.0
// ============================================================================
module pulsegap_sequencer #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 5,
   parameter int REP_W = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic [LEN_W-1:0]         pulse_len,
   input  logic [REP_W-1:0]         reps,
   input  logic                     shift_out,
   output logic [WIDTH-1:0]         load_in,
   output logic                     load,
   output logic                     pulse_out,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic [REP_W-1:0]         period_cnt,
   output logic                     err
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_load_in;
   logic [REP_W-1:0]   r_reps;
   logic [REP_W-1:0]   r_period_cnt;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic               r_load;
   logic               r_busy;
   logic               r_done;
   logic               r_stop_pending;
   logic [LEN_W-1:0]   w_plen;
   logic [WIDTH-1:0]   w_pattern;
   logic               w_period_end;
   logic               w_exit;

   // Top p bits set: bit i is high when it lies within the first p shifted out
   always_comb begin
      w_plen = (pulse_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : pulse_len;
      w_pattern = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_pattern[i] = ((WIDTH - i) <= int'(w_plen));
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_period_end = (r_bit_cnt == CNT_W'(WIDTH - 1));
      w_exit       = r_stop_pending | stop |
                     ((r_reps != '0) && (r_period_cnt == r_reps - REP_W'(1)));
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_RUN;
         S_RUN:   if (w_period_end && w_exit) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Status strobes are registered from the next state so they line up with it
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_load_in      <= '0;
         r_reps         <= '0;
         r_period_cnt   <= '0;
         r_bit_cnt      <= '0;
         r_load         <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_stop_pending <= 1'b0;
      end else begin
         r_load <= (w_state_nxt == S_LOAD);
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (w_state_nxt == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_load_in      <= w_pattern;
                  r_reps         <= reps;
                  r_period_cnt   <= '0;
                  r_stop_pending <= 1'b0;
               end
            end
            S_LOAD: r_bit_cnt <= '0;
            S_RUN: begin
               r_bit_cnt <= w_period_end ? '0 : r_bit_cnt + CNT_W'(1);
               if (stop) r_stop_pending <= 1'b1;
               if (w_period_end && (r_period_cnt != '1)) begin
                  r_period_cnt <= r_period_cnt + REP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PULSEGAP_CHECK_EN
   logic r_err;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if ((r_state == S_IDLE) && start) begin
         r_err <= 1'b0;
      end else if ((r_state == S_RUN) &&
                   (shift_out != r_load_in[CNT_W'(WIDTH - 1) - r_bit_cnt])) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign load_in    = r_load_in;
   assign load       = r_load;
   assign busy       = r_busy;
   assign done       = r_done;
   assign bit_cnt    = r_bit_cnt;
   assign period_cnt = r_period_cnt;
   assign pulse_out  = (r_state == S_RUN) & shift_out;

endmodule
`default_nettype wire

// File: tb/tb_pulsegap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulsegap_sequencer
// Purpose  : Scoreboard bench for pulsegap_sequencer with a shift-register model.
// Revision : 1.0
// ============================================================================
module tb_pulsegap_sequencer;

   localparam int WIDTH = 16;
   localparam int LEN_W = 5;
   localparam int REP_W = 8;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [LEN_W-1:0] pulse_len = '0;
   logic [REP_W-1:0] reps = '0;
   logic             shift_out;
   logic [WIDTH-1:0] load_in;
   logic             load;
   logic             pulse_out;
   logic             busy;
   logic             done;
   logic [3:0]       bit_cnt;
   logic [REP_W-1:0] period_cnt;
   logic             err;

   logic [WIDTH-1:0] sr = '0;
   logic             inj_now = 1'b0;
   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;

   typedef struct {
      int p;
      int n;
      int inj;
      int t;
   } burst_t;

   burst_t sbq[$];

   pulsegap_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
      .pulse_len(pulse_len), .reps(reps), .shift_out(shift_out),
      .load_in(load_in), .load(load), .pulse_out(pulse_out), .busy(busy),
      .done(done), .bit_cnt(bit_cnt), .period_cnt(period_cnt), .err(err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Attached circular shift register
   always @(posedge clock) begin
      if (load) sr <= load_in;
      else      sr <= {sr[WIDTH-2:0], sr[WIDTH-1]};
   end

   assign shift_out = inj_now ? 1'b0 : sr[WIDTH-1];

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endfunction

   function automatic logic [WIDTH-1:0] exp_pattern(input int p);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < p; i++) v[WIDTH-1-i] = 1'b1;
      return v;
   endfunction

   function automatic logic exp_bit(input burst_t r, input int k);
      if (k == r.inj) return 1'b0;
      return ((k % WIDTH) < r.p);
   endfunction

   function automatic logic exp_err(input burst_t r);
`ifdef PULSEGAP_CHECK_EN
      return (r.inj >= 0) && (r.inj < r.n * WIDTH) && ((r.inj % WIDTH) < r.p);
`else
      return (r.inj < -1);
`endif
   endfunction

   // Monitor: pops one expected burst per load strobe and follows it to done
   burst_t cur;
   bit     in_burst = 1'b0;
   bit     post_done = 1'b0;
   logic   cur_err = 1'b0;
   int     k = 0;
   int     wave_bad = 0;

   always @(negedge clock) begin
      if (!reset_n) begin
         in_burst  = 1'b0;
         post_done = 1'b0;
      end else begin
         if (post_done) begin
            chk("busy_after_done", busy, 0);
            chk("err_held_idle", err, cur_err);
            post_done = 1'b0;
         end
         if (load) begin
            if (sbq.size() == 0) begin
               chk("unexpected_load", 1, 0);
            end else begin
               cur = sbq.pop_front();
               chk("load_in", load_in, exp_pattern(cur.p));
               chk("start_to_load", cyc - cur.t, 1);
               chk("err_cleared", err, 0);
               chk("busy_in_load", busy, 1);
               cur_err  = exp_err(cur);
               in_burst = 1'b1;
               k        = 0;
               wave_bad = 0;
            end
         end else if (in_burst) begin
            if (done) begin
               chk("wave", wave_bad, 0);
               chk("run_len", k, cur.n * WIDTH);
               chk("done_cycle", cyc - cur.t, 2 + cur.n * WIDTH);
               chk("period_cnt", period_cnt, (cur.n > 255) ? 255 : cur.n);
               chk("err_at_done", err, cur_err);
               chk("pulse_out_in_done", pulse_out, 0);
               in_burst  = 1'b0;
               post_done = 1'b1;
            end else begin
               if (pulse_out !== exp_bit(cur, k) || bit_cnt !== 4'(k % WIDTH) || busy !== 1'b1) begin
                  if (wave_bad == 0)
                     $display("note: first wave deviation at run cycle %0d pulse_out=%b bit_cnt=%0d", k, pulse_out, bit_cnt);
                  wave_bad++;
               end
               k++;
            end
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk(tag, {7'd0, load_in, load, pulse_out, busy, done, err, bit_cnt}, 0);
      chk({tag, "_period_cnt"}, period_cnt, 0);
   endtask

   // kind: 0 none, 1 stop, 2 force shift_out low, 3 restart attempt, 4 reset; c = RUN cycle
   task automatic run_burst(input int len, input int rp, input int kind, input int c);
      burst_t r;
      int     i;
      r.p = (len > WIDTH) ? WIDTH : len;
      r.n = rp;
      if (kind == 1) begin
         r.n = c / WIDTH + 1;
         if (rp != 0 && rp < r.n) r.n = rp;
      end
      r.inj = (kind == 2) ? c : -1;
      @(negedge clock);
      pulse_len = LEN_W'(len);
      reps      = REP_W'(rp);
      start     = 1'b1;
      r.t       = cyc;
      sbq.push_back(r);
      @(posedge clock); #1 start = 1'b0;
      @(posedge clock);
      if (kind != 0) begin
         repeat (c) @(posedge clock);
         #1;
         case (kind)
            1: stop = 1'b1;
            2: inj_now = 1'b1;
            3: begin start = 1'b1; pulse_len = LEN_W'(8); end
            4: reset_n = 1'b0;
            default: ;
         endcase
         @(posedge clock); #1;
         stop    = 1'b0;
         inj_now = 1'b0;
         start   = 1'b0;
         reset_n = 1'b1;
         if (kind == 4) begin
            check_outputs_zero("reset_mid_burst");
            return;
         end
      end
      for (i = 0; i < 5000; i++) begin
         if (busy === 1'b0) break;
         @(posedge clock); #1;
      end
      if (i == 5000) chk("burst_timeout", 1, 0);
      repeat (3) @(negedge clock);
   endtask

   initial begin
      int len;
      int rp;
      int kind;
      int c;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_outputs_zero("reset_state");
      reset_n = 1'b1;

      run_burst(3, 2, 0, 0);
      run_burst(0, 1, 0, 0);
      run_burst(16, 1, 0, 0);
      run_burst(31, 1, 0, 0);
      run_burst(5, 0, 1, 40);
      run_burst(5, 1, 3, 4);

      @(negedge clock) stop = 1'b1;
      @(negedge clock) stop = 1'b0;
      @(negedge clock);
      chk("stop_in_idle_busy", busy, 0);
      run_burst(4, 1, 0, 0);

      run_burst(6, 2, 4, 7);
      run_burst(6, 1, 0, 0);
      run_burst(3, 1, 2, 1);
      run_burst(3, 1, 0, 0);

      for (int j = 0; j < 25; j++) begin
         len = $urandom_range(0, 31);
         rp  = $urandom_range(0, 3);
         if (rp == 0) begin
            kind = 1;
            c    = $urandom_range(0, 63);
         end else begin
            kind = $urandom_range(0, 3);
            c    = $urandom_range(0, rp * WIDTH - 1);
         end
         run_burst(len, rp, kind, c);
      end

      repeat (5) @(negedge clock);
      chk("scoreboard_drained", sbq.size(), 0);
      chk("monitor_idle", in_burst, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pulsegap_sequencer.md
Name: pulsegap_sequencer

Overview:
Controller for the 16-bit circular shift register that produces pulse/gap waveforms. It builds the load pattern from a requested pulse length and drives load_in/load for one cycle. It then runs the register for a programmed number of 16-cycle periods and gates shift_out onto pulse_out. It sits between the top-level pattern request logic and circ_shift_reg_16bits.

Parameters:
WIDTH, 16, shift-register length and waveform period in clocks
LEN_W, 5, width of pulse_len; must be at least clog2(WIDTH+1)
REP_W, 8, width of the repeat count and period counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  request a burst; sampled only in IDLE
stop  in  1  request graceful termination; honoured at the end of the current period
pulse_len  in  LEN_W  number of high bits per period (0..WIDTH); values above WIDTH clamp to WIDTH
reps  in  REP_W  periods per burst; 0 means continuous until stop
shift_out  in  1  serial output of the attached shift register
load_in  out  WIDTH  pattern presented to the shift register
load  out  1  parallel-load strobe to the shift register
pulse_out  out  1  gated waveform: shift_out while RUN, else 0
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse at burst completion
bit_cnt  out  clog2(WIDTH)  position within the current period
period_cnt  out  REP_W  completed periods in the current burst
err  out  1  sticky pattern-mismatch flag (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE. load=0, load_in=0, pulse_out=0, busy=0, done=0, bit_cnt=0, period_cnt=0, err=0, stop_pending=0. Reset wins over every other input, including mid-burst.
- Attached register contract: while load=1 it captures load_in at the clock edge. While load=0 it rotates one bit per clock, so shift_out presents load_in[WIDTH-1] in the first cycle after the load, then load_in[WIDTH-2], and so on, wrapping.
- Pattern: p = min(pulse_len, WIDTH). load_in has its top p bits set, e.g. p=3 gives 16'hE000. p=0 gives all zeros; p=WIDTH gives all ones. pulse_len and reps are latched when start is accepted; later changes have no effect on the running burst.
- IDLE: start=1 latches the config, clears period_cnt and stop_pending, and moves to LOAD. start is ignored in all other states.
- LOAD (exactly 1 cycle): load=1 and load_in=pattern, both registered outputs valid in this cycle. Next state is RUN, with bit_cnt=0.
- RUN: load=0, pulse_out=shift_out.
  - bit_cnt increments every cycle and wraps from WIDTH-1 to 0.
  - When bit_cnt=WIDTH-1, period_cnt increments (saturating at all ones).
  - Exit to DONE at bit_cnt=WIDTH-1 if stop_pending, or if stop=1 in that same cycle, or if reps!=0 and period_cnt==reps-1. Otherwise stay in RUN.
- stop in RUN sets stop_pending. It never truncates a period.
- stop in IDLE or LOAD is ignored.
- DONE (1 cycle): done=1, pulse_out=0, busy=1. Next state is IDLE.
- Latency: start to first pulse_out bit is 2 cycles (start edge, LOAD cycle, first RUN cycle). Waveform output per burst is exactly reps*WIDTH cycles.
- pulse_out is combinational from shift_out and the state register. All other outputs are registered.

Optional Feature:
PULSEGAP_CHECK_EN
- Defined: in each RUN cycle, compare shift_out with the latched pattern bit at index WIDTH-1-bit_cnt. Any mismatch sets err. err is sticky until the next accepted start or reset.
- Not defined: err is tied to 0 and no compare logic is built.

Test Plan:
- Basic burst: pulse_len=3, reps=2, start pulse.
  - LOAD cycle has load=1, load_in=16'hE000.
  - pulse_out is 1 for RUN cycles 0-2 and 16-18, 0 for the other 26 cycles.
  - done=1 exactly 34 cycles after start is sampled; busy then falls.
- Extremes: pulse_len=0 gives load_in=0 and pulse_out=0 for 16 cycles. pulse_len=16 and pulse_len=31 both give load_in=16'hFFFF and pulse_out=1 for all 16 cycles (reps=1).
- Continuous with stop: reps=0, pulse_len=5, stop pulsed at RUN cycle 40 → run ends after bit_cnt=15 of period 2, done at cycle 48 of RUN, period_cnt=3.
- Ignored inputs: start re-asserted and pulse_len changed to 8 mid-burst → waveform unchanged (5 high / 11 low), no second burst. stop pulsed in IDLE → no effect.
- Reset mid-operation: reset_n=0 at RUN cycle 7 → next cycle all outputs 0 and IDLE. A fresh start afterwards gives the normal 2-cycle latency.
- With PULSEGAP_CHECK_EN: force shift_out=0 at RUN cycle 1 for pulse_len=3 → err=1 and it stays high through DONE and IDLE. The next start clears it. Without the macro, err stays 0.
